// File: rtl/pipe_skid_reg.sv
// Ready/valid pipeline register with a 2-entry skid buffer, flush and occupancy.
// Optional perf counters (stall_cnt, full_cnt) exist when PIPE_SKID_PERF_EN is defined.
module pipe_skid_reg #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      full_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    if (flush) begin
      // Any out_fire this cycle already completed downstream; in_fire is dropped.
      state_d     = EMPTY;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d      = in_data;
            state_d     = BUSY;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d     = in_data;
            state_d    = FULL;
            in_ready_d = 1'b0;
          end else if (out_fire) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;
            if (CLEAR_DATA) main_d = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d     = skid_q;
            state_d    = BUSY;
            in_ready_d = 1'b1;
            if (CLEAR_DATA) skid_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] full_q, full_d;

  // Saturating counters; flush deliberately leaves them untouched.
  always_comb begin
    stall_d = stall_q;
    full_d  = full_q;
    if (out_valid_q && !out_ready && stall_q != '1) stall_d = stall_q + 32'd1;
    if (state_q == FULL && full_q != '1)            full_d  = full_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      full_q  <= '0;
    end else begin
      stall_q <= stall_d;
      full_q  <= full_d;
    end
  end

  assign stall_cnt = stall_q;
  assign full_cnt  = full_q;
`else
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed steps then randomized traffic vs a queue-based model.
// Perf counter checks are compiled in when PIPE_SKID_PERF_EN is defined.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
`ifdef PIPE_SKID_PERF_EN
  logic [31:0] stall_cnt, full_cnt;
  int unsigned m_stall, m_full;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
`ifdef PIPE_SKID_PERF_EN
    , .stall_cnt(stall_cnt), .full_cnt(full_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_data",  out_data, (mq.size() > 0) ? mq[0] : 32'd0);
    chk("in_ready",  32'(in_ready), 32'(mq.size() < 2));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
`ifdef PIPE_SKID_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("full_cnt",  full_cnt, m_full);
`endif
  endtask

  // One clock: drive inputs, advance the FIFO model on the edge, check after it.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] d, input logic ordy);
    bit can_in, has_out;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    can_in  = mq.size() < 2;
    has_out = mq.size() > 0;
    if (rst) begin
      mq.delete();
`ifdef PIPE_SKID_PERF_EN
      m_stall = 0; m_full = 0;
`endif
    end else begin
`ifdef PIPE_SKID_PERF_EN
      if (has_out && !ordy) m_stall++;
      if (mq.size() == 2)   m_full++;
`endif
      if (fl) mq.delete();
      else begin
        if (has_out && ordy) void'(mq.pop_front());
        if (iv && can_in)    mq.push_back(d);
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    bit          hold_iv;
    logic [31:0] hold_d;
    logic        iv;
    logic [31:0] d;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef PIPE_SKID_PERF_EN
    m_stall = 0; m_full = 0;
`endif
    // Reset then idle
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    // Streaming
    step(0, 0, 1, 32'h11, 1);
    step(0, 0, 1, 32'h22, 1);
    step(0, 0, 1, 32'h33, 1);
    step(0, 0, 0, 32'h0, 1);
    // Backpressure and skid, A3 held by upstream until accepted
    step(0, 0, 1, 32'hA1, 0);
    step(0, 0, 1, 32'hA2, 0);
    step(0, 0, 1, 32'hA3, 0);
    step(0, 0, 1, 32'hA3, 0);
    step(0, 0, 1, 32'hA3, 1);
    step(0, 0, 1, 32'hA3, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // Flush in FULL with a concurrent push
    step(0, 0, 1, 32'hB1, 0);
    step(0, 0, 1, 32'hB2, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 0);
    step(0, 1, 1, 32'hB3, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // Reset mid-operation
    step(0, 0, 1, 32'hC1, 0);
    step(0, 0, 1, 32'hC2, 0);
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // Randomized traffic; upstream holds a refused beat
    hold_iv = 0; hold_d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_iv) begin
        iv = 1'b1; d = hold_d;
      end else begin
        iv = ($urandom_range(0, 3) != 0);
        d  = $urandom();
      end
      hold_iv = iv && !in_ready;
      hold_d  = d;
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 31) == 0),
           iv, d, ($urandom_range(0, 2) != 0));
      if (reset || flush) hold_iv = 0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
